packet_former_ctrl: RTL and testbench

//  Transmit sequencer downstream of the channel arbiter (rdy_cnl/next pair).

---
 rtl/packet_former_ctrl_if.sv | 23 ++
 rtl/packet_former_ctrl.sv | 108 ++++++++++
 tb/tb_packet_former_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/packet_former_ctrl_if.sv
// packet_former_ctrl_if: arbiter grant, FIFO read ports and tx byte stream of the packet former
interface packet_former_ctrl_if;
  logic [1:0] rdy_cnl;
  logic [7:0] f1_dout;
  logic [7:0] f2_dout;
  logic [7:0] f3_dout;
  logic       f1_rd;
  logic       f2_rd;
  logic       f3_rd;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       next;
  logic       busy;
  modport master (
    input  rdy_cnl, f1_dout, f2_dout, f3_dout, tx_ready,
    output f1_rd, f2_rd, f3_rd, tx_data, tx_valid, next, busy
  );
  modport slave (
    output rdy_cnl, f1_dout, f2_dout, f3_dout, tx_ready,
    input  f1_rd, f2_rd, f3_rd, tx_data, tx_valid, next, busy
  );
endinterface

// File: rtl/packet_former_ctrl.sv
// packet_former_ctrl: frames the granted channel's FIFO bytes as SYNC, HDR, payload, CHK on a valid/ready stream
module packet_former_ctrl #(
  parameter int         PAYLOAD_LEN = 30,
  parameter int         GAP_CYC     = 2,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input logic clk,
  input logic rst_n,
  packet_former_ctrl_if.master bus
);
  localparam int GW = $clog2(GAP_CYC + 1);
  typedef enum logic [2:0] {S_GAP, S_SYNC, S_HDR, S_PAY, S_CHK, S_DONE} state_t;
  state_t        state, state_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [1:0]    ch, ch_nx;
  logic [5:0]    idx, idx_nx;
  logic [7:0]    chk, chk_nx;
  logic [7:0]    data, data_nx;
  logic          valid, valid_nx;
  logic          nxt, nxt_nx;
  logic [7:0]    pay;
  logic [2:0]    rd;
  logic          free;
  assign free = !valid || bus.tx_ready;
  assign pay  = ch == 2'd1 ? bus.f1_dout : ch == 2'd2 ? bus.f2_dout : ch == 2'd3 ? bus.f3_dout : 8'h00;
  assign bus.tx_data  = data;
  assign bus.tx_valid = valid;
  assign bus.next     = nxt;
  assign bus.busy     = state != S_GAP;
  assign bus.f1_rd    = rd[0];
  assign bus.f2_rd    = rd[1];
  assign bus.f3_rd    = rd[2];
  // next state and output slot: a byte is loaded only when the slot is free, a stalled byte holds
  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    ch_nx    = ch;
    idx_nx   = idx;
    chk_nx   = chk;
    data_nx  = data;
    valid_nx = valid && !bus.tx_ready;
    nxt_nx   = 1'b0;
    rd       = 3'b000;
    case (state)
      S_GAP: begin
        gap_nx = gap + 1'b1;
        if (gap == GW'(GAP_CYC - 1)) begin
          gap_nx   = '0;
          ch_nx    = bus.rdy_cnl;
          state_nx = S_SYNC;
        end
      end
      S_SYNC: if (free) begin
        data_nx  = SYNC_BYTE;
        valid_nx = 1'b1;
        chk_nx   = 8'h00;
        state_nx = S_HDR;
      end
      S_HDR: if (free) begin
        data_nx  = {6'b0, ch};
        valid_nx = 1'b1;
        chk_nx   = {6'b0, ch};
        idx_nx   = '0;
        state_nx = S_PAY;
      end
      S_PAY: if (free) begin
        data_nx  = pay;
        valid_nx = 1'b1;
        chk_nx   = chk ^ pay;
        idx_nx   = idx + 1'b1;
        rd       = {ch == 2'd3, ch == 2'd2, ch == 2'd1};
        state_nx = idx == 6'(PAYLOAD_LEN - 1) ? S_CHK : S_PAY;
      end
      S_CHK: if (free) begin
        data_nx  = chk;
        valid_nx = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE: if (valid && bus.tx_ready) begin
        nxt_nx   = 1'b1;
        state_nx = S_GAP;
      end
      default: state_nx = S_GAP;
    endcase
  end
  // state and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_GAP;
      gap   <= '0;
      ch    <= '0;
      idx   <= '0;
      chk   <= '0;
      data  <= '0;
      valid <= 1'b0;
      nxt   <= 1'b0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
      ch    <= ch_nx;
      idx   <= idx_nx;
      chk   <= chk_nx;
      data  <= data_nx;
      valid <= valid_nx;
      nxt   <= nxt_nx;
    end
  end
endmodule

// File: tb/tb_packet_former_ctrl.sv
// tb_packet_former_ctrl: directed and randomized frames checked against a queue-based frame model
module tb_packet_former_ctrl;
  localparam int PL  = 30;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic rst_n;
  packet_former_ctrl_if bus();
  packet_former_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // FIFO contents and first-word-fall-through read pointers
  logic [7:0] mem [1:3][0:1023];
  logic [9:0] p1 = '0, p2 = '0, p3 = '0;
  assign bus.f1_dout = mem[1][p1];
  assign bus.f2_dout = mem[2][p2];
  assign bus.f3_dout = mem[3][p3];
  always @(posedge clk) begin
    if (bus.f1_rd) p1 <= p1 + 1'b1;
    if (bus.f2_rd) p2 <= p2 + 1'b1;
    if (bus.f3_rd) p3 <= p3 + 1'b1;
  end
  // stream monitor, sampled mid-cycle
  logic [7:0] got[$];
  int rd_cnt [1:3] = '{0, 0, 0};
  int next_cnt = 0, stab_err = 0, stall_rd_err = 0, multi_err = 0, nohs_err = 0;
  int idle = 0, min_idle = 1000;
  bit seen = 1'b0, prev_stall = 1'b0, prev_hs = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_hs    <= 1'b0;
      idle       <= 0;
    end else begin
      if (prev_stall && bus.tx_data !== prev_data) stab_err <= stab_err + 1;
      if (bus.tx_valid && !bus.tx_ready && (bus.f1_rd || bus.f2_rd || bus.f3_rd)) stall_rd_err <= stall_rd_err + 1;
      if (int'(bus.f1_rd) + int'(bus.f2_rd) + int'(bus.f3_rd) > 1) multi_err <= multi_err + 1;
      rd_cnt[1] <= rd_cnt[1] + int'(bus.f1_rd);
      rd_cnt[2] <= rd_cnt[2] + int'(bus.f2_rd);
      rd_cnt[3] <= rd_cnt[3] + int'(bus.f3_rd);
      if (bus.next) begin
        next_cnt <= next_cnt + 1;
        if (!prev_hs) nohs_err <= nohs_err + 1;
      end
      if (bus.tx_valid) begin
        if (seen && idle != 0 && idle < min_idle) min_idle <= idle;
        idle <= 0;
        seen <= 1'b1;
      end else idle <= idle + 1;
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      prev_hs    <= bus.tx_valid && bus.tx_ready;
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
    end
  end
  int errors = 0, checks = 0;
  int ep [1:3] = '{0, 0, 0};
  int last_st = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // one frame: mode 0 ready high, 1 five-cycle stall mid-payload, 2 random ready
  task automatic frame(input int c, input int mode, input bit toggle, input bit post_rst);
    logic [7:0] e[$];
    logic [7:0] x, b, d0;
    int st, nc0, n, r0;
    int rc0 [1:3];
    bit stalled;
    bus.rdy_cnl = 2'(c);
    st = got.size();
    nc0 = next_cnt;
    rc0 = rd_cnt;
    x = 8'(c);
    e.push_back(8'hA5);
    e.push_back(8'(c));
    for (int i = 0; i < PL; i++) begin
      b = c != 0 ? mem[c][ep[c] + i] : 8'h00;
      e.push_back(b);
      x ^= b;
    end
    e.push_back(x);
    if (c != 0) ep[c] += PL;
    if (post_rst) begin
      rst_n = 1'b1;
      step;
      chk("lat_idle0", 32'(bus.tx_valid), 0);
      step;
      chk("lat_idle1", 32'(bus.tx_valid), 0);
      step;
      chk("lat_valid", 32'(bus.tx_valid), 1);
      chk("lat_sync", 32'(bus.tx_data), 32'h A5);
    end
    n = 0;
    stalled = 1'b0;
    while (next_cnt == nc0 && n < 600) begin
      if (toggle && got.size() > st) bus.rdy_cnl = 2'($urandom_range(0, 3));
      if (mode == 2) bus.tx_ready = $urandom_range(0, 3) != 0;
      if (mode == 1 && !stalled && got.size() - st >= 12) begin
        stalled = 1'b1;
        bus.tx_ready = 1'b0;
        d0 = bus.tx_data;
        r0 = rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
        repeat (5) step;
        chk("stall_hold", 32'(bus.tx_data), 32'(d0));
        chk("stall_no_rd", rd_cnt[1] + rd_cnt[2] + rd_cnt[3], r0);
        bus.tx_ready = 1'b1;
      end
      step;
      n++;
    end
    chk("next_seen", next_cnt - nc0, 1);
    chk("next_1cyc", 32'(bus.next), 0);
    bus.tx_ready = 1'b1;
    chk("frame_len", got.size() - st, PL + 3);
    for (int i = 0; i < e.size(); i++)
      if (st + i < got.size()) chk($sformatf("ch%0d_byte%0d", c, i), 32'(got[st + i]), 32'(e[i]));
    for (int k = 1; k <= 3; k++) chk($sformatf("rd_cnt%0d", k), rd_cnt[k] - rc0[k], k == c ? PL : 0);
    last_st = st;
  endtask
  initial begin
    int st, nc0, n, c;
    for (int k = 1; k <= 3; k++)
      for (int i = 0; i < 1024; i++) mem[k][i] = 8'($urandom);
    for (int i = 0; i < PL; i++) mem[1][i] = 8'(i + 1);
    rst_n = 1'b0;
    bus.tx_ready = 1'b1;
    bus.rdy_cnl = 2'd1;
    step;
    step;
    chk("rst_valid", 32'(bus.tx_valid), 0);
    chk("rst_data", 32'(bus.tx_data), 0);
    chk("rst_next", 32'(bus.next), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rd", 32'({bus.f1_rd, bus.f2_rd, bus.f3_rd}), 0);
    frame(1, 0, 1'b0, 1'b1);
    if (got.size() > last_st + 32) chk("t1_chk", 32'(got[last_st + 32]), 32'h1E);
    frame(0, 0, 1'b0, 1'b0);
    frame(3, 1, 1'b0, 1'b0);
    frame(1, 0, 1'b0, 1'b0);
    frame(2, 0, 1'b0, 1'b0);
    frame(3, 0, 1'b0, 1'b0);
    frame(0, 0, 1'b0, 1'b0);
    frame(2, 0, 1'b1, 1'b0);
    frame(1, 2, 1'b1, 1'b0);
    repeat (6) frame(int'($urandom_range(0, 3)), 2, 1'b1, 1'b0);
    bus.rdy_cnl = 2'd2;
    st = got.size();
    nc0 = next_cnt;
    n = 0;
    while (got.size() - st < 12 && n < 200) begin
      step;
      n++;
    end
    chk("abort_reached", 32'(got.size() - st >= 12), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(bus.tx_valid), 0);
    chk("abort_data", 32'(bus.tx_data), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_rd", 32'({bus.f1_rd, bus.f2_rd, bus.f3_rd}), 0);
    step;
    step;
    chk("abort_no_next", next_cnt, nc0);
    frame(1, 0, 1'b0, 1'b1);
    repeat (4) begin
      c = int'($urandom_range(0, 2));
      frame(c == 2 ? 3 : c, 2, 1'b1, 1'b0);
    end
    chk("stall_stable", stab_err, 0);
    chk("stall_rd", stall_rd_err, 0);
    chk("one_rd", multi_err, 0);
    chk("next_after_hs", nohs_err, 0);
    chk("min_gap", 32'(min_idle >= GAP), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
